sr04_meas: RTL

//  Ultrasonic range front-end for sensor channel 1; sits between the s1_trig/s1_echo pads and the

---
 rtl/sr04_pkg.sv | 24 ++
 rtl/sr04_meas_if.sv | 16 +
 rtl/sync2.sv | 24 ++
 rtl/sr04_meas.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/sr04_pkg.sv
// Shared types and defaults for the SR04 ultrasonic range front-end.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package sr04_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TRIG,
      ST_WAIT,
      ST_MEAS,
      ST_DONE,
      ST_HOLD
   } state_t;

   localparam int TRIG_US_DEF    = 10;
   localparam int PERIOD_US_DEF  = 60000;
   localparam int TIMEOUT_US_DEF = 38000;
   localparam int US_PER_CM      = 58;
   localparam int DW_DEF         = 16;

   // Reported distance when the echo never arrived or never ended.
   localparam logic [15:0] DIST_ERR_VAL = 16'hFFFF;

endpackage

// File: rtl/sr04_meas_if.sv
// Result bus from the range front-end to the reporting logic.
// Latency: n/a (wires only).
// Backpressure: none; consumer must sample on dist_vld.
interface sr04_meas_if #(
   parameter int DW = sr04_pkg::DW_DEF
) ();

   logic          dist_vld;
   logic [DW-1:0] dist_cm;
   logic          dist_err;
   logic          busy;

   modport master (output dist_vld, dist_cm, dist_err, busy);
   modport slave  (input  dist_vld, dist_cm, dist_err, busy);

endinterface

// File: rtl/sync2.sv
// Generic two-flop synchroniser for a single asynchronous level.
// Latency: 2 clk cycles.
// Backpressure: none.
module sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   // Two back-to-back flops to settle metastability before use.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/sr04_meas.sv
// SR04 channel front-end: periodic trigger, echo timing, width-to-cm conversion.
// Latency: dist_vld 3 cycles after the echo pin falls (2 sync + 1 result register).
// Backpressure: none; one strobe per measurement, results hold between strobes.
module sr04_meas #(
   parameter int TRIG_US    = sr04_pkg::TRIG_US_DEF,
   parameter int PERIOD_US  = sr04_pkg::PERIOD_US_DEF,
   parameter int TIMEOUT_US = sr04_pkg::TIMEOUT_US_DEF,
   parameter int US_PER_CM  = sr04_pkg::US_PER_CM,
   parameter int DW         = sr04_pkg::DW_DEF
) (
   input  logic        clk_1m,
   input  logic        rst_n,
   input  logic        meas_en,
   output logic        s1_trig,
   input  logic        s1_echo,
   sr04_meas_if.master res
);

   import sr04_pkg::*;

   localparam int PW = $clog2(PERIOD_US + 1);
   localparam int WW = $clog2(TIMEOUT_US + 1);
   localparam int SW = $clog2(US_PER_CM + 1);

   // Highest centimetre count; one below all-ones so a saturated reading
   // can never be confused with the error code.
   localparam logic [DW-1:0] CM_MAX  = {{(DW-1){1'b1}}, 1'b0};
   localparam logic [DW-1:0] ERR_VAL = DW'(DIST_ERR_VAL);

   state_t         state;
   logic [PW-1:0]  period_cnt;
   logic [WW-1:0]  wait_cnt;     // WAIT: cycles since trigger fell; MEAS: echo width
   logic [SW-1:0]  sub_cnt;      // microseconds within the current centimetre
   logic [DW-1:0]  cm_cnt;
   logic           echo_s;
   logic           echo_q;
   logic           echo_rise;
   logic           echo_fall;
   logic           period_last;
   logic           wait_last;
   logic           sub_wrap;
   logic [DW-1:0]  cm_nxt;

   sync2 u_echo_sync (
      .clk   (clk_1m),
      .rst_n (rst_n),
      .d     (s1_echo),
      .q     (echo_s)
   );

   // Previous synchronised echo level for edge detection.
   always_ff @(posedge clk_1m or negedge rst_n) begin
      if (!rst_n) echo_q <= 1'b0;
      else        echo_q <= echo_s;
   end

   // Edge detects, counter terminal conditions and next centimetre count.
   always_comb begin
      echo_rise   = echo_s & ~echo_q;
      echo_fall   = ~echo_s & echo_q;
      period_last = (period_cnt == PW'(PERIOD_US - 1));
      wait_last   = (wait_cnt == WW'(TIMEOUT_US - 1));
      sub_wrap    = (sub_cnt == SW'(US_PER_CM - 1));
      cm_nxt      = cm_cnt;
      if (sub_wrap && (cm_cnt != CM_MAX)) cm_nxt = cm_cnt + 1'b1;
   end

   // Trigger-to-trigger timebase; parked at 0 in IDLE so a new run starts aligned.
   always_ff @(posedge clk_1m or negedge rst_n) begin
      if (!rst_n)                 period_cnt <= '0;
      else if (state == ST_IDLE)  period_cnt <= '0;
      else if (period_last)       period_cnt <= '0;
      else                        period_cnt <= period_cnt + 1'b1;
   end

   // Measurement sequencer with registered trigger, result and busy outputs.
   always_ff @(posedge clk_1m or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         s1_trig      <= 1'b0;
         wait_cnt     <= '0;
         sub_cnt      <= '0;
         cm_cnt       <= '0;
         res.dist_vld <= 1'b0;
         res.dist_cm  <= '0;
         res.dist_err <= 1'b0;
         res.busy     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (meas_en) begin
                  state    <= ST_TRIG;
                  s1_trig  <= 1'b1;
                  res.busy <= 1'b1;
               end
            end
            ST_TRIG: begin
               // period_cnt restarts at 0 with the trigger, so it doubles as the pulse timer.
               if (period_cnt == PW'(TRIG_US - 1)) begin
                  state    <= ST_WAIT;
                  s1_trig  <= 1'b0;
                  wait_cnt <= '0;
               end
            end
            ST_WAIT: begin
               if (echo_rise) begin
                  state    <= ST_MEAS;
                  cm_cnt   <= '0;
                  sub_cnt  <= '0;
                  wait_cnt <= '0;
               end else if (wait_last) begin
                  state        <= ST_DONE;
                  res.dist_vld <= 1'b1;
                  res.dist_cm  <= ERR_VAL;
                  res.dist_err <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ST_MEAS: begin
               // The fall-detect cycle is still an echo-high microsecond, so it is counted.
               if (echo_fall) begin
                  state        <= ST_DONE;
                  res.dist_vld <= 1'b1;
                  res.dist_cm  <= cm_nxt;
                  res.dist_err <= 1'b0;
               end else if (wait_last) begin
                  state        <= ST_DONE;
                  res.dist_vld <= 1'b1;
                  res.dist_cm  <= ERR_VAL;
                  res.dist_err <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
                  sub_cnt  <= sub_wrap ? '0 : sub_cnt + 1'b1;
                  cm_cnt   <= cm_nxt;
               end
            end
            ST_DONE: begin
               res.dist_vld <= 1'b0;
               state        <= ST_HOLD;
            end
            ST_HOLD: begin
               if (period_last) begin
                  if (meas_en) begin
                     state   <= ST_TRIG;
                     s1_trig <= 1'b1;
                  end else begin
                     state    <= ST_IDLE;
                     res.busy <= 1'b0;
                  end
               end
            end
            default: begin
               state    <= ST_IDLE;
               s1_trig  <= 1'b0;
               res.busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
